// File: rtl/pipelined_adder.sv
// pipelined_adder: nbit-wide add/subtract split into nstage ripple-carry
// chunks, one chunk per pipeline stage, with a single global advance so the
// whole pipe either shifts or holds.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand set present on a, b, cin, sub
//   in_ready   operand set accepted this cycle (= global advance)
//   a, b       operands, nbit each
//   cin        carry-in (add only; forced to 1 in subtract)
//   sub        0 = a + b + cin, 1 = a - b
//   out_valid  s, cout, ovf hold a result
//   out_ready  downstream takes the result this cycle
//   s          sum/difference modulo 2^nbit
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
module pipelined_adder #(
    parameter int nbit   = 32,
    parameter int nstage = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [nbit-1:0] a,
    input  logic [nbit-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [nbit-1:0] s,
    output logic            cout,
    output logic            ovf
);

    localparam int w = nbit / nstage;

    if (nstage < 1 || (nbit % nstage) != 0) begin : g_cfg_check
        $error("pipelined_adder: nbit must be a multiple of nstage");
    end

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar k;
    for (k = 0; k < nstage; k++) begin : g_stage
        // operand bits of b still waiting to be consumed after this stage
        localparam int rem = nbit - (k + 1) * w;

        // as_q holds the unconsumed chunks of a in its low part and the
        // finished sum chunks in its high part; each stage eats the lowest
        // chunk and inserts its sum chunk at the top, so after nstage stages
        // the register holds the complete, aligned sum. a[nbit-1] rides
        // along in the same register until the last stage reads it.
        logic [nbit-1:0] as_in;
        logic [nbit-1:0] as_nxt;
        logic [nbit-1:0] as_q;
        logic [w-1:0]    bc_raw;
        logic [w-1:0]    bc;
        logic            c_in;
        logic            sub_in;
        logic            v_in;
        logic [w:0]      sum;
        logic            c_q;
        logic            v_q;

        if (k == 0) begin : g_src
            assign as_in  = a;
            assign bc_raw = b[w-1:0];
            assign sub_in = sub;
            assign c_in   = sub | cin;
            assign v_in   = in_valid;
        end else begin : g_src
            assign as_in  = g_stage[k-1].as_q;
            assign bc_raw = g_stage[k-1].g_skew.b_q[w-1:0];
            assign sub_in = g_stage[k-1].g_skew.sub_q;
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
        end

        // subtract is a + ~b + 1; the +1 enters as stage 0's carry-in
        assign bc     = sub_in ? ~bc_raw : bc_raw;
        assign sum    = {1'b0, as_in[w-1:0]} + {1'b0, bc} + {{w{1'b0}}, c_in};
        assign as_nxt = (as_in >> w) | (nbit'(sum[w-1:0]) << (nbit - w));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                as_q <= '0;
                c_q  <= 1'b0;
                v_q  <= 1'b0;
            end else if (adv) begin
                as_q <= as_nxt;
                c_q  <= sum[w];
                v_q  <= v_in;
            end
        end

        if (k < nstage - 1) begin : g_skew
            // b shrinks by one chunk per stage; sub travels alongside
            logic [rem-1:0] b_rest;
            logic [rem-1:0] b_q;
            logic           sub_q;

            if (k == 0) begin : g_rest
                assign b_rest = b[nbit-1:w];
            end else begin : g_rest
                assign b_rest = g_stage[k-1].g_skew.b_q[rem+w-1:w];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (adv) begin
                    b_q   <= b_rest;
                    sub_q <= sub_in;
                end
            end
        end else begin : g_out
            // bc[w-1] is b's sign already inverted for subtract
            logic ovf_nxt;
            logic ovf_q;

            assign ovf_nxt = (as_in[w-1] == bc[w-1]) && (sum[w-1] != as_in[w-1]);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_nxt;
                end
            end
        end
    end

    assign s         = g_stage[nstage-1].as_q;
    assign cout      = g_stage[nstage-1].c_q;
    assign ovf       = g_stage[nstage-1].g_out.ovf_q;
    assign out_valid = g_stage[nstage-1].v_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on a 4-stage instance plus a
// randomized valid/ready run shared by 4-, 1- and 8-stage instances, each
// scored against an arithmetic reference through per-instance queues.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;

    logic        rdy [3];
    logic        vld [3];
    logic [31:0] so  [3];
    logic        co  [3];
    logic        of  [3];

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] exp_q [3][$];
    logic [31:0] got_q [$];
    string       nm [3] = '{"n4", "n1", "n8"};

    always #5 clk = ~clk;

    pipelined_adder #(.nbit(32), .nstage(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(vld[0]),
        .out_ready(out_ready), .s(so[0]), .cout(co[0]), .ovf(of[0]));

    pipelined_adder #(.nbit(32), .nstage(1)) u_n1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(vld[1]),
        .out_ready(out_ready), .s(so[1]), .cout(co[1]), .ovf(of[1]));

    pipelined_adder #(.nbit(32), .nstage(8)) u_n8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(vld[2]),
        .out_ready(out_ready), .s(so[2]), .cout(co[2]), .ovf(of[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // {ovf, cout, s} from plain integer arithmetic on the operands
    function automatic logic [33:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic c, input logic m);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint u;
        longint t;
        logic   rc;
        logic   ro;
        if (m) begin
            u  = ux - uy;
            t  = sx - sy;
            rc = (ux >= uy);
        end else begin
            u  = ux + uy + longint'(c);
            t  = sx + sy + longint'(c);
            rc = (u >= 64'sd4294967296);
        end
        ro = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        return {ro, rc, u[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // a reset throws away everything in flight
    always @(negedge reset_n) begin
        for (int i = 0; i < 3; i++) exp_q[i].delete();
    end

    logic [33:0] sb_e;
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && out_ready) begin
                    if (exp_q[i].size() == 0) begin
                        chk({"spurious_", nm[i]}, 64'(vld[i]), 64'd0);
                    end else begin
                        sb_e = exp_q[i].pop_front();
                        chk({"res_", nm[i]}, 64'({of[i], co[i], so[i]}), 64'(sb_e));
                        if (i == 0) got_q.push_back(so[0]);
                    end
                end
                if (in_valid && rdy[i]) exp_q[i].push_back(ref_model(a, b, cin, sub));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic tcin, input logic tsub,
                           input logic [31:0] es, input logic ec, input logic eo);
        int lat = 0;
        a = ta; b = tb; cin = tcin; sub = tsub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (lat < 12) begin
            step();
            lat++;
            in_valid = 1'b0;
            if (vld[0]) break;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk({tag, "_s"}, 64'(so[0]), 64'(es));
        chk({tag, "_cout"}, 64'(co[0]), 64'(ec));
        chk({tag, "_ovf"}, 64'(of[0]), 64'(eo));
    endtask

    task automatic t_backpressure();
        int          idx = 0;
        int          stall = 0;
        bit          stalled = 1'b0;
        logic [31:0] held = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        got_q.delete();
        for (int cyc = 0; cyc < 100 && got_q.size() < 8; cyc++) begin
            in_valid = (idx < 8);
            a = 32'(idx); b = 32'(idx); cin = 1'b0; sub = 1'b0;
            if (!stalled && vld[0]) begin
                stalled = 1'b1;
                stall   = 3;
                held    = so[0];
            end
            out_ready = (stall == 0);
            @(negedge clk);
            if (stall > 0) begin
                chk("bp_in_ready", 64'(rdy[0]), 64'd0);
                chk("bp_s_hold", 64'(so[0]), 64'(held));
                chk("bp_valid_hold", 64'(vld[0]), 64'd1);
                stall--;
            end
            if (in_valid && rdy[0]) idx++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_stalled", 64'(stalled), 64'd1);
        chk("bp_count", 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            chk("bp_order", 64'(got_q[i]), 64'(2 * i));
        end
    endtask

    task automatic t_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + 32'(i); b = 32'h11; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("pre_rst_valid", 64'(vld[0]), 64'd1);
        chk("pre_rst_s", 64'(so[0]), 64'h111);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(vld[0]), 64'd0);
        chk("rst_s", 64'(so[0]), 64'd0);
        chk("rst_cout", 64'(co[0]), 64'd0);
        chk("rst_ovf", 64'(of[0]), 64'd0);
        chk("rst_in_ready", 64'(rdy[0]), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        chk("rst_rel_in_ready", 64'(rdy[0]), 64'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_no_stale", 64'(vld[0]), 64'd0);
        end
        run_one("post_rst", 32'h0000_1234, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_1334, 1'b0, 1'b0);
    endtask

    task automatic t_random();
        int acc  = 0;
        bit hold = 1'b0;
        for (int cyc = 0; cyc < 40000 && acc < 10000; cyc++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a   = pick();
                b   = pick();
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hold = in_valid && !rdy[0];
            if (in_valid && rdy[0]) acc++;
            step();
        end
        chk("rand_accepted", 64'(acc), 64'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            step();
        end
        for (int i = 0; i < 3; i++) chk({"drain_", nm[i]}, 64'(exp_q[i].size()), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        chk("reset_in_ready", 64'(rdy[0]), 64'd1);
        chk("reset_valid", 64'(vld[0]), 64'd0);
        chk("reset_s", 64'(so[0]), 64'd0);
        chk("reset_cout", 64'(co[0]), 64'd0);
        chk("reset_ovf", 64'(of[0]), 64'd0);
        #20;
        reset_n = 1'b1;
        step();

        run_one("add_16b", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        run_one("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        t_backpressure();
        t_reset_midflight();
        t_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter nbit, default 32: operand/result width in bits.
REQ-002 SHALL have parameter nstage, default 4: pipeline stage count; nbit SHALL be an integer multiple of nstage, checked at elaboration.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand set present on a, b, cin, sub.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a, b  input  nbit each  unsigned/two's-complement operands.
REQ-008 cin  input  1  carry-in, add mode only.
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  s, cout, ovf hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 s  output  nbit  sum/difference.
REQ-013 cout  output  1  carry-out of MSB (subtract: 1 = no borrow).
REQ-014 ovf  output  1  signed two's-complement overflow.

Function
REQ-015 Chunk width w = nbit/nstage; stage k (0..nstage-1) SHALL add bits [k*w+w-1 : k*w] with a ripple-carry chain whose carry-in is stage k-1's registered carry (stage 0: effective carry-in).
REQ-016 Add: result = a + b + cin; subtract: result = a + ~b + 1, cin ignored.
REQ-017 Operand chunks not yet consumed SHALL travel in skew registers; completed sum chunks SHALL travel in deskew registers so all nbit of s emerge together.
REQ-018 Each stage SHALL carry a valid bit; sub and the operand-sign bits a[nbit-1], b[nbit-1] SHALL travel with the transaction.
REQ-019 Global advance: adv = !out_valid || out_ready; in_ready SHALL equal adv (combinational, no dependence on in_valid).
REQ-020 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-021 When adv = 1 every stage register SHALL shift one stage; when adv = 0 all stage registers, s, cout, ovf, out_valid SHALL hold.
REQ-022 Latency SHALL be exactly nstage cycles from transfer in to out_valid assertion, with no stalls.
REQ-023 Throughput SHALL be one transaction per cycle with out_ready held 1; bubbles (in_valid = 0) SHALL propagate as invalid stages, never as duplicated results.
REQ-024 ovf SHALL be computed from the final-stage signs: ovf = (sa == sb') && (s[nbit-1] != sa), with sb' = b sign inverted when sub = 1.
REQ-025 cout SHALL be the carry-out of stage nstage-1.
REQ-026 Results SHALL emerge in acceptance order; no transaction SHALL be dropped or reordered across any stall pattern.
REQ-027 nstage = 1 SHALL degrade to a single registered ripple-carry add with latency 1.
REQ-028 Overflow/wrap: s SHALL be result modulo 2^nbit; no saturation.

Reset
REQ-029 reset_n low SHALL immediately clear all stage valid bits, out_valid, s, cout, ovf to 0, regardless of clock.
REQ-030 in_ready SHALL read 1 while out_valid = 0, including during and right after reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight transactions; no result from before reset SHALL ever appear.

Verification (nbit = 32, nstage = 4)
REQ-032 Add: a=0x0000_FFFF, b=0x0000_0001, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, s=0x0001_0000, cout=0, ovf=0.
REQ-033 Carry across all chunks: a=0xFFFF_FFFF, b=0, cin=1 -> s=0x0000_0000, cout=1, ovf=0; a=0x7FFF_FFFF, b=1, cin=0 -> s=0x8000_0000, ovf=1.
REQ-034 Subtract: a=5, b=7, sub=1, cin=1 -> s=0xFFFF_FFFE, cout=0, ovf=0; a=0x8000_0000, b=1, sub=1 -> s=0x7FFF_FFFF, cout=1, ovf=1.
REQ-035 Back-pressure: stream 8 back-to-back adds (a=i, b=i), hold out_ready=0 for 3 cycles once first result valid -> in_ready=0 during stall, s held stable, all 8 results 2i delivered in order, none lost or duplicated.
REQ-036 Reset mid-flight: issue 3 adds, assert reset_n=0 asynchronously between edges after 2 cycles -> out_valid, s, cout, ovf go 0 at once; after release no stale result appears and the next add completes in 4 cycles.
REQ-037 Random: 10k random a, b, cin, sub with random in_valid/out_ready toggling checked against a reference model for s, cout, ovf and ordering, also repeated for nstage=1 and nstage=8.
